// File: rtl/clkdiv_sched.sv
// Run-time divided-clock generator with period-boundary divisor updates
// and start/stop sequencing for the PWM channel clock path.
module clkdiv_sched #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = 10,
    parameter int unsigned MIN_DIV     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             div_valid,
    input  logic [WIDTH-1:0] div_data,
    output logic             div_ready,
    input  logic             err_clr,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] cur_div,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] pending_d;
    logic [WIDTH-1:0] cur_div_d;
    logic             clk_out_d;
    logic             tick_d;
    logic             busy_d;
    logic             err_d;
    logic             xfer;
    logic             div_bad;
    logic             div_ok;
    logic             period_end;

    // Handshake qualification: an undersized divisor is consumed but only flags an error
    assign div_ready  = (state_q != ST_PENDING);
    assign xfer       = div_valid & div_ready;
    assign div_bad    = xfer & (div_data < WIDTH'(MIN_DIV));
    assign div_ok     = xfer & ~div_bad;
    assign period_end = (cnt_q == (cur_div - WIDTH'(1)));

    // Next-state, counter, divisor update and registered-output decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = period_end ? '0 : (cnt_q + WIDTH'(1));
        cur_div_d = cur_div;
        pending_d = pending_q;
        clk_out_d = (state_q != ST_STOPPED) && (cnt_q < (cur_div >> 1));
        tick_d    = (state_q != ST_STOPPED) && (cnt_q == '0);
        err_d     = div_bad | (err & ~err_clr);

        case (state_q)
            ST_STOPPED: begin
                cnt_d = '0;
                if (div_ok) begin
                    cur_div_d = div_data;
                end
                if (enable) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (period_end && !enable) begin
                    // Stopping on this boundary: a divisor accepted now takes effect directly
                    state_d = ST_STOPPED;
                    if (div_ok) begin
                        cur_div_d = div_data;
                    end
                end else if (div_ok) begin
                    pending_d = div_data;
                    state_d   = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (period_end) begin
                    cur_div_d = pending_q;
                    state_d   = enable ? ST_RUNNING : ST_STOPPED;
                end
            end
            default: begin
                state_d = ST_STOPPED;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == ST_PENDING);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_STOPPED;
            cnt_q     <= '0;
            pending_q <= '0;
            cur_div   <= WIDTH'(DEFAULT_DIV);
            clk_out   <= 1'b0;
            tick      <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            cur_div   <= cur_div_d;
            clk_out   <= clk_out_d;
            tick      <= tick_d;
            busy      <= busy_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_clkdiv_sched.sv
// Randomized and directed bench for clkdiv_sched against a cycle-level behavioural model.
module tb_clkdiv_sched;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             div_valid;
    logic [WIDTH-1:0] div_data;
    logic             div_ready;
    logic             err_clr;
    logic             clk_out;
    logic             tick;
    logic [WIDTH-1:0] cur_div;
    logic             busy;
    logic             err;

    int n_total = 0;
    int n_bad   = 0;

    // Behavioural model: running flag, pending flag, position within the period
    bit          m_run;
    bit          m_pv;
    int unsigned m_cnt;
    int unsigned m_div;
    int unsigned m_pend;
    bit          m_err;
    bit          e_clk;
    bit          e_tick;

    clkdiv_sched #(
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(10),
        .MIN_DIV    (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .div_valid(div_valid),
        .div_data (div_data),
        .div_ready(div_ready),
        .err_clr  (err_clr),
        .clk_out  (clk_out),
        .tick     (tick),
        .cur_div  (cur_div),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock given the inputs presented for that edge
    task automatic model_step(input bit r, input bit en, input bit v,
                              input logic [31:0] d, input bit c);
        bit acc;
        bit bad;
        bit last;
        if (r) begin
            m_run = 0; m_pv = 0; m_cnt = 0; m_div = 10; m_err = 0;
            e_clk = 0; e_tick = 0;
        end else begin
            acc    = v && !m_pv;
            bad    = acc && (d < 2);
            e_clk  = m_run && (m_cnt < m_div / 2);
            e_tick = m_run && (m_cnt == 0);
            last   = m_run && (m_cnt == m_div - 1);
            if (bad) m_err = 1;
            else if (c) m_err = 0;
            if (!m_run) begin
                if (acc && !bad) m_div = d;
                m_run = en;
                m_cnt = 0;
            end else begin
                m_cnt = last ? 0 : m_cnt + 1;
                if (last && m_pv) begin
                    m_div = m_pend;
                    m_pv  = 0;
                    m_run = en;
                end else if (last && !en) begin
                    m_run = 0;
                    if (acc && !bad) m_div = d;
                end else if (acc && !bad) begin
                    m_pv   = 1;
                    m_pend = d;
                end
            end
        end
    endtask

    // Drive inputs at the falling edge, clock once, then compare DUT to model
    task automatic step(input bit r, input bit en, input bit v,
                        input logic [31:0] d, input bit c);
        @(negedge clk);
        reset = r; enable = en; div_valid = v; div_data = d; err_clr = c;
        model_step(r, en, v, d, c);
        @(posedge clk);
        #1;
        check("m_clk_out", 32'(clk_out), 32'(e_clk));
        check("m_tick", 32'(tick), 32'(e_tick));
        check("m_busy", 32'(busy), 32'(m_pv));
        check("m_err", 32'(err), 32'(m_err));
        check("m_cur_div", cur_div, m_div);
        check("m_div_ready", 32'(div_ready), 32'(!m_pv));
    endtask

    task automatic wait_tick(input bit en);
        int n = 0;
        do begin
            step(0, en, 0, 0, 0);
            n++;
        end while (!tick && n < 40);
        check("wait_tick", 32'(tick), 32'd1);
    endtask

    task automatic wait_idle(input bit en);
        int n = 0;
        do begin
            step(0, en, 0, 0, 0);
            n++;
        end while (busy && n < 40);
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int hi;
        int ticks;
        reset = 1; enable = 0; div_valid = 0; div_data = '0; err_clr = 0;

        // Reset state
        step(1, 0, 0, 0, 0);
        check("rst_cur_div", cur_div, 32'd10);
        check("rst_ready", 32'(div_ready), 32'd1);
        check("rst_clk_out", 32'(clk_out), 32'd0);

        // Start with default divisor: tick two cycles after enable, 5 high / 5 low
        step(0, 1, 0, 0, 0);
        check("t1_no_tick_yet", 32'(tick), 32'd0);
        step(0, 1, 0, 0, 0);
        check("t1_first_tick", 32'(tick), 32'd1);
        hi = int'(clk_out); ticks = 0;
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 0, 0, 0);
            hi += int'(clk_out); ticks += int'(tick);
        end
        check("t1_high_cycles", 32'(hi), 32'd5);
        check("t1_extra_ticks", 32'(ticks), 32'd0);
        step(0, 1, 0, 0, 0);
        check("t1_period10", 32'(tick), 32'd1);

        // Divisor 7 offered at counter 3: busy for the remaining 6 cycles
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 7, 0);
        check("t2_ready_low", 32'(div_ready), 32'd0);
        hi = int'(busy);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 0);
            hi += int'(busy);
        end
        check("t2_busy_cycles", 32'(hi), 32'd6);
        step(0, 1, 0, 0, 0);
        check("t2_applied", cur_div, 32'd7);
        check("t2_ready_back", 32'(div_ready), 32'd1);
        step(0, 1, 0, 0, 0);
        check("t2_tick", 32'(tick), 32'd1);
        hi = int'(clk_out);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 0, 0);
            hi += int'(clk_out);
        end
        check("t2_high_cycles", 32'(hi), 32'd3);
        step(0, 1, 0, 0, 0);
        check("t2_period7", 32'(tick), 32'd1);

        // Undersized divisor sets sticky error; set wins over simultaneous clear
        step(0, 1, 1, 1, 0);
        check("t3_err_set", 32'(err), 32'd1);
        check("t3_div_kept", cur_div, 32'd7);
        step(0, 1, 0, 0, 1);
        check("t3_err_clr", 32'(err), 32'd0);
        step(0, 1, 1, 0, 1);
        check("t3_set_wins", 32'(err), 32'd1);
        step(0, 1, 0, 0, 1);

        // D=6, drop enable at counter 2: period finishes then output stays quiet
        step(0, 1, 1, 6, 0);
        wait_idle(1);
        check("t4_div6", cur_div, 32'd6);
        wait_tick(1);
        hi = int'(clk_out); ticks = 0;
        step(0, 1, 0, 0, 0);
        hi += int'(clk_out);
        for (int i = 0; i < 14; i++) begin
            step(0, 0, 0, 0, 0);
            hi += int'(clk_out); ticks += int'(tick);
        end
        check("t4_high_cycles", 32'(hi), 32'd3);
        check("t4_no_tick", 32'(ticks), 32'd0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check("t4_restart_tick", 32'(tick), 32'd1);

        // Pending divisor 4 with enable dropped: applied at the stopping boundary
        step(0, 1, 1, 4, 0);
        check("t5_busy", 32'(busy), 32'd1);
        wait_idle(0);
        check("t5_div4", cur_div, 32'd4);
        check("t5_ready", 32'(div_ready), 32'd1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("t5_stopped_clk", 32'(clk_out), 32'd0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check("t5_tick", 32'(tick), 32'd1);
        hi = int'(clk_out);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0);
            hi += int'(clk_out);
        end
        check("t5_high_cycles", 32'(hi), 32'd2);
        step(0, 1, 0, 0, 0);
        check("t5_period4", 32'(tick), 32'd1);

        // Reset while a divisor is pending discards it
        step(0, 1, 1, 9, 0);
        check("t6_pending", 32'(busy), 32'd1);
        step(1, 1, 0, 0, 0);
        check("t6_clk_out", 32'(clk_out), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_cur_div", cur_div, 32'd10);
        check("t6_ready", 32'(div_ready), 32'd1);
        check("t6_err", 32'(err), 32'd0);
        for (int i = 0; i < 25; i++) step(0, 1, 0, 0, 0);
        check("t6_never_applied", cur_div, 32'd10);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(199) == 0),
                 ($urandom_range(9) != 0),
                 ($urandom_range(7) == 0),
                 32'($urandom_range(12)),
                 ($urandom_range(15) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/clkdiv_sched.md
Name: clkdiv_sched

Overview:
- Run-time controller for the PWM clock-divider path.
- Generates a divided clock `clk_out` and a one-cycle `tick` at each period start.
- Accepts new divisor values through a valid/ready handshake and applies them only at a period boundary, so `clk_out` never has a runt pulse.
- Sits between the register/config interface and the PWM channels, and provides start/stop sequencing of the divided clock.

Parameters:
- WIDTH, 32, width of divisor and period counter.
- DEFAULT_DIV, 10, divisor loaded at reset.
- MIN_DIV, 2, smallest accepted divisor. Must be at least 2; smaller requests are rejected.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = run divided clock, 0 = stop at end of current period.
- div_valid  in  1  new divisor offered.
- div_data  in  WIDTH  offered divisor value.
- div_ready  out  1  controller can accept a divisor this cycle.
- err_clr  in  1  clears sticky error flag.
- clk_out  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse, registered, aligned with the first high cycle of each period.
- cur_div  out  WIDTH  divisor currently in effect.
- busy  out  1  an accepted divisor is waiting for the period boundary.
- err  out  1  sticky; a divisor below MIN_DIV was offered.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All state updates on the rising edge of `clk`.
- Reset values:
  - state = STOPPED, counter = 0, pending = 0.
  - `cur_div` = DEFAULT_DIV.
  - `clk_out` = 0, `tick` = 0, `busy` = 0, `err` = 0, `div_ready` = 1.
- Reset mid-operation: returns every register to its reset value immediately. A pending divisor is discarded. `clk_out` is 0 on the cycle after reset is sampled.
- Handshake:
  - Transfer occurs when `div_valid` and `div_ready` are both 1.
  - `div_ready` = 1 in STOPPED and RUNNING, 0 in PENDING. It is combinational from state.
  - If `div_data` < MIN_DIV, the transfer is still consumed, `err` sets, and nothing else changes.
- States:
  - STOPPED:
    - counter held at 0.
    - Accepted divisor loads `cur_div` the next cycle.
    - `enable` = 1 → RUNNING, counter = 0.
  - RUNNING:
    - counter counts 0 … `cur_div` − 1 and wraps to 0.
    - Accepted valid divisor is stored in `pending`; state → PENDING; `busy` = 1 from the next cycle.
  - PENDING:
    - counting continues with the old `cur_div`.
    - On the cycle counter = `cur_div` − 1: `cur_div` ← pending, counter ← 0, state → RUNNING, `busy` ← 0.
- Stop:
  - In RUNNING or PENDING with `enable` = 0 at counter = `cur_div` − 1: state → STOPPED, counter ← 0.
  - If in PENDING, the pending divisor is applied on that same boundary.
  - If `enable` returns to 1 before the boundary, no stop occurs.
- Outputs, one cycle after the counter value that produces them:
  - `clk_out`(n+1) = 1 iff state(n) ≠ STOPPED and counter(n) < `cur_div`(n) >> 1.
  - `tick`(n+1) = 1 iff state(n) ≠ STOPPED and counter(n) = 0.
  - Period = D cycles: high for floor(D/2) cycles, low for ceil(D/2) cycles.
- Latency: `enable` sampled at cycle 0 → RUNNING at cycle 1 → first `tick` and `clk_out` high at cycle 2.
- Arithmetic: counter and compare are unsigned WIDTH-bit. No counter overflow is possible because `cur_div` ≤ 2^WIDTH − 1.
- `err`: `err_clr` clears it. If a new error and `err_clr` occur in the same cycle, set wins.
- `enable` and divisor acceptance in the same cycle while STOPPED: the divisor is loaded and running starts together, so the first period uses the new divisor.

Test Plan:
1. Reset, then `enable` = 1 with DEFAULT_DIV = 10 → first `tick` 2 cycles after `enable`; `clk_out` 5 high / 5 low; `tick` every 10 cycles; `cur_div` = 10.
2. While RUNNING (D = 10), offer `div_data` = 7 at counter 3 → `div_ready` drops, `busy` = 1 for the remaining 6 cycles. Next period is 7 cycles (3 high / 4 low); `busy` → 0 and `div_ready` → 1 at the boundary.
3. Offer `div_data` = 1 (MIN_DIV = 2) → `err` = 1, `cur_div` unchanged, output period unchanged. Then pulse `err_clr` → `err` = 0. Error and `err_clr` in the same cycle → `err` = 1.
4. RUNNING at D = 6, drop `enable` at counter 2 → current period completes (3 high / 3 low), then `clk_out` stays 0 and no `tick`. Re-raise `enable` → restart with `tick` 2 cycles later.
5. PENDING (new D = 4) with `enable` dropped → at the boundary state is STOPPED, `cur_div` = 4, `busy` = 0. Re-enable → 2 high / 2 low periods.
6. Assert `reset` mid-PENDING → next cycle: `clk_out` = 0, `busy` = 0, `cur_div` = 10, `div_ready` = 1, `err` = 0. Pending value is never applied.
